// File: rtl/kbd_fifo_arbiter_pkg.sv
// Shared constants for the keyboard/character FIFO push-side arbiter.
// Source IDs and default widths used by the arbiter and its FIFO instance.
package kbd_fifo_arbiter_pkg;

  localparam int SRC_PS2      = 0;
  localparam int SRC_UART     = 1;
  localparam int KBD_ARB_NREQ = 2;
  localparam int KBD_WORD_W   = 8;
  localparam int KBD_ARB_SRCW = 1;

  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  // Round-robin pointer width: clog2(n), never below one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kbd_fifo_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from rr_ptr upward, mod NREQ.
// Kept generic so a pop-side scheduler can reuse it.
module arb_rr_pick #(
  parameter int NREQ = 2,
  parameter int PTRW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] rr_ptr,
  output logic            grant_vld,
  output logic [PTRW-1:0] grant_idx
);

  int w_idx;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_vld = 1'b0;
    grant_idx = '0;
    w_idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_vld && req[w_idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTRW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/kbd_fifo_arbiter.sv
// Round-robin arbiter sharing the keyboard FIFO push port between non-stallable byte sources.
// Optional per-source drop counters are built when KBD_ARB_STATS_EN is defined.
module kbd_fifo_arbiter
  import kbd_fifo_arbiter_pkg::*;
#(
  parameter int NREQ  = KBD_ARB_NREQ,
  parameter int WIDTH = KBD_WORD_W,
  parameter int SRCW  = KBD_ARB_SRCW
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_stb,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic                  fifo_notfull,
  output logic                  fifo_push,
  output logic [SRCW+WIDTH-1:0] fifo_data,
  output logic                  busy,
  output logic [NREQ-1:0]       ovf,
  input  logic [NREQ-1:0]       ovf_clr
`ifdef KBD_ARB_STATS_EN
  ,
  output logic [NREQ*8-1:0]     drop_cnt
`endif
);

  localparam int PTRW = ptr_width(NREQ);

  logic [NREQ-1:0]            r_hold_vld;
  logic [NREQ-1:0][WIDTH-1:0] r_hold_data;
  logic [PTRW-1:0]            r_rr_ptr;
  logic [NREQ-1:0]            r_ovf;

  logic            w_grant_vld;
  logic [PTRW-1:0] w_grant_idx;
  logic            w_push;
  logic [PTRW-1:0] w_rr_next;
  logic [NREQ-1:0] w_drain;
  logic [NREQ-1:0] w_drop;
  logic [NREQ-1:0] w_load;

  arb_rr_pick #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .req       (r_hold_vld),
    .rr_ptr    (r_rr_ptr),
    .grant_vld (w_grant_vld),
    .grant_idx (w_grant_idx)
  );

  assign w_push    = w_grant_vld & fifo_notfull;
  assign w_rr_next = (w_grant_idx == PTRW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

  // A hold being drained this cycle can accept a new strobe; only an undrained full hold drops.
  always_comb begin
    w_drain = '0;
    w_drop  = '0;
    w_load  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_drain[i] = w_push && (w_grant_idx == PTRW'(i));
      w_drop[i]  = req_stb[i] && r_hold_vld[i] && !w_drain[i];
      w_load[i]  = req_stb[i] && !w_drop[i];
    end
  end

  assign fifo_push = w_push;
  assign fifo_data = w_push ? {SRCW'(w_grant_idx), r_hold_data[w_grant_idx]} : '0;
  assign busy      = |r_hold_vld;
  assign ovf       = r_ovf;

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: hold data is reset too, so fifo_data can never expose a word from before reset.
      r_hold_vld  <= '0;
      r_hold_data <= '0;
      r_rr_ptr    <= '0;
      r_ovf       <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_load[i]) begin
          r_hold_vld[i]  <= 1'b1;
          r_hold_data[i] <= req_data[i*WIDTH +: WIDTH];
        end else if (w_drain[i]) begin
          r_hold_vld[i]  <= 1'b0;
        end
        if (w_drop[i])       r_ovf[i] <= 1'b1;
        else if (ovf_clr[i]) r_ovf[i] <= 1'b0;
      end
      if (w_push) r_rr_ptr <= w_rr_next;
    end
  end

`ifdef KBD_ARB_STATS_EN
  logic [NREQ-1:0][7:0] r_drop_cnt;

  // Clear and drop together leave a count of one: the new drop is not lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_drop_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ovf_clr[i])
          r_drop_cnt[i] <= w_drop[i] ? 8'd1 : 8'd0;
        else if (w_drop[i] && r_drop_cnt[i] != DROP_CNT_MAX)
          r_drop_cnt[i] <= r_drop_cnt[i] + 8'd1;
      end
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule
